// File: rtl/roulette_bet_pkg.sv
// Shared types and constants for the roulette bet ledger.
package roulette_bet_pkg;

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_LOCKED,
    ST_CLEAR
  } ledger_state_e;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned AMT_W   = 2;
  localparam int unsigned ENTRY_W = AMT_W + OPC_W;

  localparam logic [OPC_W-1:0] SPIN_OPC   = 6'b111110;
  localparam logic [OPC_W-1:0] CANCEL_OPC = 6'b111111;

  typedef struct packed {
    logic [AMT_W-1:0] amount;
    logic [OPC_W-1:0] opcode;
  } entry_t;

endpackage

// File: rtl/bet_ledger_hold_timer.sv
// Retriggerable down-counter: active stays high for exactly HOLD_CYCLES
// cycles after the most recent trigger.
module hold_timer #(
  parameter  int unsigned HOLD_CYCLES = 100_000_000,
  localparam int unsigned CW          = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger,
  output logic active
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on trigger, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = CW'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/bet_ledger.sv
// Bet-capture ledger: stores up to MAX_BETS {amount, opcode} entries,
// supports undo of the last bet, locks during a spin and clears on settle.
// Optional build macro BET_LEDGER_MERGE_EN: a repeated opcode adds its
// amount (saturating) into the lowest matching live entry instead of appending.
module bet_ledger
  import roulette_bet_pkg::*;
#(
  parameter  int unsigned          MAX_BETS      = 12,
  parameter  int unsigned          OPCODE_W      = OPC_W,
  parameter  int unsigned          AMOUNT_W      = AMT_W,
  parameter  logic [OPCODE_W-1:0]  SPIN_OPCODE   = SPIN_OPC,
  parameter  logic [OPCODE_W-1:0]  CANCEL_OPCODE = CANCEL_OPC,
  parameter  int unsigned          HOLD_CYCLES   = 100_000_000,
  localparam int unsigned          IDX_W         = (MAX_BETS > 1) ? $clog2(MAX_BETS) : 1,
  localparam int unsigned          CNT_W         = $clog2(MAX_BETS + 1),
  localparam int unsigned          EW            = AMOUNT_W + OPCODE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bet_valid,
  input  logic [OPCODE_W-1:0] bet_opcode,
  input  logic [AMOUNT_W-1:0] bet_amount,
  input  logic                amount_valid,
  input  logic                settle_done,
  input  logic [IDX_W-1:0]    rd_index,
  output logic [EW-1:0]       rd_data,
  output logic [CNT_W-1:0]    bet_count,
  output logic                full,
  output logic                empty,
  output logic                spin_active,
  output logic                accept_pulse,
  output logic                reject_pulse,
  output logic                bet_received
);

  ledger_state_e     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [EW-1:0]     entries_q [MAX_BETS];
  logic [EW-1:0]     entries_d [MAX_BETS];
  logic              acc_q, acc_d;
  logic              rej_q, rej_d;
  logic [EW-1:0]     rd_q, rd_d;
  logic              trig;
  logic              is_spin, is_cancel, is_full;

`ifdef BET_LEDGER_MERGE_EN
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [AMOUNT_W:0] merge_sum;
`endif

  assign is_spin   = (bet_opcode == SPIN_OPCODE);
  assign is_cancel = (bet_opcode == CANCEL_OPCODE);
  assign is_full   = (count_q == CNT_W'(MAX_BETS));

  // Next-state, ledger update and pulse decisions.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    entries_d = entries_q;
    acc_d     = 1'b0;
    rej_d     = 1'b0;
    trig      = 1'b0;
`ifdef BET_LEDGER_MERGE_EN
    hit       = 1'b0;
    hit_idx   = '0;
    merge_sum = '0;
    for (int unsigned i = 0; i < MAX_BETS; i++) begin
      if (!hit && (CNT_W'(i) < count_q) && (entries_q[i][OPCODE_W-1:0] == bet_opcode)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    merge_sum = {1'b0, entries_q[hit_idx][EW-1 -: AMOUNT_W]} + {1'b0, bet_amount};
`endif
    unique case (state_q)
      ST_OPEN: begin
        if (bet_valid) begin
          if (is_spin) begin
            if (count_q != '0) begin
              state_d = ST_LOCKED;
              acc_d   = 1'b1;
            end else begin
              rej_d = 1'b1;
            end
          end else if (is_cancel) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
              for (int unsigned i = 0; i < MAX_BETS; i++) begin
                if (CNT_W'(i) == count_d) entries_d[i] = '0;
              end
              acc_d = 1'b1;
            end else begin
              rej_d = 1'b1;
            end
          end else if (!amount_valid) begin
            rej_d = 1'b1;
`ifdef BET_LEDGER_MERGE_EN
          end else if (hit) begin
            // Merging never needs a free slot, so it is checked before full.
            entries_d[hit_idx][EW-1 -: AMOUNT_W] =
              merge_sum[AMOUNT_W] ? '1 : merge_sum[AMOUNT_W-1:0];
            acc_d = 1'b1;
            trig  = 1'b1;
`endif
          end else if (is_full) begin
            rej_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < MAX_BETS; i++) begin
              if (CNT_W'(i) == count_q) entries_d[i] = {bet_amount, bet_opcode};
            end
            count_d = count_q + 1'b1;
            acc_d   = 1'b1;
            trig    = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (settle_done) state_d = ST_CLEAR;
        rej_d = bet_valid;
      end
      ST_CLEAR: begin
        state_d   = ST_OPEN;
        count_d   = '0;
        entries_d = '{default: '0};
        rej_d     = bet_valid;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // Registered read port: selects from the pre-update entries.
  always_comb begin
    rd_d = '0;
    for (int unsigned i = 0; i < MAX_BETS; i++) begin
      if (IDX_W'(i) == rd_index) rd_d = entries_q[i];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Ledger contents, count, pulses and read data registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      entries_q <= '{default: '0};
      acc_q     <= 1'b0;
      rej_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
      acc_q     <= acc_d;
      rej_q     <= rej_d;
      rd_q      <= rd_d;
    end
  end

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clock   (clock),
    .reset   (reset),
    .trigger (trig),
    .active  (bet_received)
  );

  assign rd_data      = rd_q;
  assign bet_count    = count_q;
  assign full         = is_full;
  assign empty        = (count_q == '0);
  assign spin_active  = (state_q != ST_OPEN);
  assign accept_pulse = acc_q;
  assign reject_pulse = rej_q;

endmodule

// File: tb/tb_bet_ledger.sv
// Directed plus randomized bench for bet_ledger against a queue-based model.
module tb_bet_ledger;
  import roulette_bet_pkg::*;

  localparam int MB   = 12;
  localparam int HOLD = 10;
  localparam logic [5:0] SPIN   = 6'h3E;
  localparam logic [5:0] CANCEL = 6'h3F;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       bet_valid = 1'b0;
  logic [5:0] bet_opcode = '0;
  logic [1:0] bet_amount = '0;
  logic       amount_valid = 1'b0;
  logic       settle_done = 1'b0;
  logic [3:0] rd_index = '0;
  logic [7:0] rd_data;
  logic [3:0] bet_count;
  logic       full, empty, spin_active, accept_pulse, reject_pulse, bet_received;

  always #5 clock = ~clock;

  bet_ledger #(
    .MAX_BETS    (MB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bet_valid    (bet_valid),
    .bet_opcode   (bet_opcode),
    .bet_amount   (bet_amount),
    .amount_valid (amount_valid),
    .settle_done  (settle_done),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .bet_count    (bet_count),
    .full         (full),
    .empty        (empty),
    .spin_active  (spin_active),
    .accept_pulse (accept_pulse),
    .reject_pulse (reject_pulse),
    .bet_received (bet_received)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: ledger as a queue, phase 0=open 1=locked 2=clearing.
  logic [7:0] led[$];
  int         phase;
  int         cyc = 0;
  int         last_trig;
  logic       e_acc, e_rej;
  logic [7:0] e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    led.delete();
    phase     = 0;
    last_trig = -1000000;
    e_acc     = 1'b0;
    e_rej     = 1'b0;
    e_rd      = '0;
  endtask

  function automatic logic [7:0] led_at(input int i);
    return (i < led.size()) ? led[i] : 8'h00;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":count"}, 32'(bet_count), 32'(led.size()));
    chk({tag, ":full"},  32'(full),  32'(led.size() == MB));
    chk({tag, ":empty"}, 32'(empty), 32'(led.size() == 0));
    chk({tag, ":spin"},  32'(spin_active), 32'(phase != 0));
    chk({tag, ":acc"},   32'(accept_pulse), 32'(e_acc));
    chk({tag, ":rej"},   32'(reject_pulse), 32'(e_rej));
    chk({tag, ":brx"},   32'(bet_received), 32'((cyc - last_trig) < HOLD));
    chk({tag, ":rd"},    32'(rd_data), 32'(e_rd));
  endtask

  task automatic step(input string tag, input logic bv, input logic [5:0] opc,
                      input logic [1:0] amt, input logic av, input logic st,
                      input logic [3:0] idx);
    int         hit;
    int         s;
    logic [7:0] e;
    bet_valid    = bv;
    bet_opcode   = opc;
    bet_amount   = amt;
    amount_valid = av;
    settle_done  = st;
    rd_index     = idx;
    @(posedge clock);
    cyc++;
    e_rd  = led_at(int'(idx));
    e_acc = 1'b0;
    e_rej = 1'b0;
    hit   = -1;
    if (phase == 2) begin
      led.delete();
      phase = 0;
      e_rej = bv;
    end else if (phase == 1) begin
      if (st) phase = 2;
      e_rej = bv;
    end else if (bv) begin
      if (opc == SPIN) begin
        if (led.size() > 0) begin phase = 1; e_acc = 1'b1; end
        else e_rej = 1'b1;
      end else if (opc == CANCEL) begin
        if (led.size() > 0) begin void'(led.pop_back()); e_acc = 1'b1; end
        else e_rej = 1'b1;
      end else if (!av) begin
        e_rej = 1'b1;
      end else begin
`ifdef BET_LEDGER_MERGE_EN
        foreach (led[i]) if (hit < 0 && led[i][5:0] == opc) hit = i;
`endif
        if (hit >= 0) begin
          e = led[hit];
          s = int'(e[7:6]) + int'(amt);
          e[7:6] = (s > 3) ? 2'd3 : 2'(s);
          led[hit] = e;
          e_acc = 1'b1;
          last_trig = cyc;
        end else if (led.size() < MB) begin
          led.push_back({amt, opc});
          e_acc = 1'b1;
          last_trig = cyc;
        end else begin
          e_rej = 1'b1;
        end
      end
    end
    #1;
    bet_valid   = 1'b0;
    settle_done = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic [3:0] idx);
    step(tag, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, idx);
  endtask

  task automatic bet(input string tag, input logic [5:0] opc, input logic [1:0] amt);
    step(tag, 1'b1, opc, amt, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    logic [5:0] base;
    int         r;
    logic       bv, av, st;
    logic [5:0] opc;

    model_reset();
    #12 reset = 1'b1;
    idle("rst_state", 4'd0);

    // Async reset mid-operation with 5 bets and a spin in progress.
    for (int i = 0; i < 5; i++) bet("pre5", 6'($urandom_range(0, 61)), 2'($urandom_range(0, 3)));
    bet("pre_spin", SPIN, 2'd0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i <= MB; i++) idle("rst_sweep", 4'(i));

    // Three bets, a repeat opcode, then cancel; read back entries.
    bet("b05", 6'h05, 2'd1);
    bet("b11", 6'h11, 2'd2);
    bet("b05b", 6'h05, 2'd3);
    bet("cancel", CANCEL, 2'd0);
    for (int i = 0; i < 4; i++) idle("rd_after_cancel", 4'(i));
    while (led.size() > 0) bet("drain", CANCEL, 2'd0);

    // Fill to capacity with distinct opcodes, then overflow.
    base = 6'($urandom_range(0, 49));
    for (int i = 0; i < MB; i++) bet("fill", base + 6'(i), 2'($urandom_range(0, 3)));
    bet("overflow", base + 6'd12, 2'd1);
    idle("rd_e11", 4'd11);
    idle("rd_e11b", 4'd11);
    while (led.size() > 0) bet("drain", CANCEL, 2'd0);
    bet("cancel_empty", CANCEL, 2'd0);

    // Spin handling.
    bet("spin_empty", SPIN, 2'd0);
    for (int i = 0; i < 3; i++) bet("pre_spin3", 6'($urandom_range(0, 61)), 2'($urandom_range(0, 3)));
    step("settle_open", 1'b0, 6'h00, 2'd0, 1'b0, 1'b1, 4'd0);
    bet("spin3", SPIN, 2'd0);
    bet("bet_locked", 6'h07, 2'd1);
    idle("locked_idle", 4'd1);
    step("settle_and_bet", 1'b1, 6'h08, 2'd2, 1'b1, 1'b1, 4'd0);
    bet("bet_in_clear", 6'h09, 2'd1);
    idle("after_clear", 4'd0);

    // Hold timer with retrigger four cycles later.
    bet("hold_t0", 6'h01, 2'd1);
    for (int i = 0; i < 3; i++) idle("hold_gap", 4'd0);
    bet("hold_retrig", 6'h02, 2'd2);
    for (int i = 0; i < 12; i++) idle("hold_tail", 4'd0);

    // Missing chip amount and out-of-range reads.
    step("no_amount", 1'b1, 6'h04, 2'd3, 1'b0, 1'b0, 4'd0);
    idle("rd_idx12", 4'd12);
    idle("rd_idx15", 4'd15);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 99));
      bv = (r < 65);
      r  = int'($urandom_range(0, 99));
      if (r < 8)       opc = SPIN;
      else if (r < 22) opc = CANCEL;
      else             opc = 6'($urandom_range(0, 9));
      av = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 7) == 0);
      step("rand", bv, opc, 2'($urandom_range(0, 3)), av, st, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
